// File: rtl/sequencer_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : sequencer_ctrl_if
//  Description : Bundle of the signals exchanged between the hardwired
//                sequencer and the Phase-1 Datapath.
//                master : the sequencer (reads run/mem_ready/ir, drives the
//                         Datapath controls and the status outputs)
//                slave  : the Datapath / environment side
//  Signals     : run        - level, begin/continue execution from IDLE
//                mem_ready  - memory data valid on MDataIn this cycle
//                ir         - current Datapath IR contents
//                busSelect  - one-hot bus source select
//                enable     - register load enables
//                alu_op     - ALU operation code
//                IncPC      - ALU adds 1 to the bus operand
//                MR_Read    - MDR mux selects MDataIn
//                state      - current sequencer state (debug)
//                halted     - sequencer is in HALT
//                trap       - 00 none, 01 illegal opcode, 10 fetch timeout
//  Revision    : 1.0  initial release
// ============================================================================
interface sequencer_ctrl_if;
   logic        run;
   logic        mem_ready;
   logic [31:0] ir;
   logic [31:0] busSelect;
   logic [31:0] enable;
   logic [4:0]  alu_op;
   logic        IncPC;
   logic        MR_Read;
   logic [3:0]  state;
   logic        halted;
   logic [1:0]  trap;

   modport master (
      input  run, mem_ready, ir,
      output busSelect, enable, alu_op, IncPC, MR_Read, state, halted, trap
   );

   modport slave (
      output run, mem_ready, ir,
      input  busSelect, enable, alu_op, IncPC, MR_Read, state, halted, trap
   );
endinterface
`default_nettype wire

// File: rtl/sequencer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : sequencer_ctrl
//  Description : Hardwired control unit sequencing the Phase-1 Datapath
//                through fetch (T0-T2), decode (T3) and execute (T4-T6)
//                for register-register ALU instructions. Handles a
//                memory-ready wait in T1 with timeout, run/halt, and
//                illegal-opcode trapping. Moore outputs decoded from the
//                current state and the IR contents.
//  Ports       : clk - system clock, rising edge
//                clr - asynchronous active-low reset
//                bus - sequencer_ctrl_if.master (run, mem_ready, ir in;
//                      busSelect, enable, alu_op, IncPC, MR_Read, state,
//                      halted, trap out)
//  Revision    : 1.0  initial release
// ============================================================================
module sequencer_ctrl #(
   parameter int MAX_WAIT         = 15,
   parameter bit RESET_STATE_IDLE = 1'b1
) (
   input  logic              clk,
   input  logic              clr,
   sequencer_ctrl_if.master  bus
);

   localparam logic [3:0] S_IDLE = 4'd0;
   localparam logic [3:0] S_T0   = 4'd1;
   localparam logic [3:0] S_T1   = 4'd2;
   localparam logic [3:0] S_T2   = 4'd3;
   localparam logic [3:0] S_T3   = 4'd4;
   localparam logic [3:0] S_T4   = 4'd5;
   localparam logic [3:0] S_T5   = 4'd6;
   localparam logic [3:0] S_T6   = 4'd7;
   localparam logic [3:0] S_HALT = 4'd8;

   localparam logic [3:0] RESET_STATE = RESET_STATE_IDLE ? S_IDLE : S_T0;
   // Last counter value before the timeout fires: the MAX_WAIT-th low cycle.
   localparam logic [3:0] WAIT_LAST   = 4'(MAX_WAIT - 1);

   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_MUL  = 5'b01111;
   localparam logic [4:0] OP_DIV  = 5'b10000;
   localparam logic [4:0] OP_NEG  = 5'b10001;
   localparam logic [4:0] OP_NOT  = 5'b10010;
   localparam logic [4:0] OP_NOP  = 5'b11010;
   localparam logic [4:0] OP_HALT = 5'b11011;

   localparam logic [1:0] TRAP_ILLEGAL = 2'b01;
   localparam logic [1:0] TRAP_TIMEOUT = 2'b10;

   logic [3:0]  cur_state, next_state;
   logic [3:0]  wait_cnt, next_cnt;
   logic [1:0]  trap_q, next_trap;

   logic [4:0]  opcode;
   logic [3:0]  ra, rb, rc;
   logic        is_binary, is_muldiv, is_unary, is_nop, is_halt;

   logic [31:0] bus_sel;
   logic [31:0] load_en;
   logic [4:0]  op;
   logic        inc_pc, mr_read;

   assign opcode = bus.ir[31:27];
   assign ra     = bus.ir[26:23];
   assign rb     = bus.ir[22:19];
   assign rc     = bus.ir[18:15];

   // add..rol occupy the contiguous range 00011-01011
   assign is_binary = (opcode >= OP_ADD) && (opcode <= 5'b01011);
   assign is_muldiv = (opcode == OP_MUL) || (opcode == OP_DIV);
   assign is_unary  = (opcode == OP_NEG) || (opcode == OP_NOT);
   assign is_nop    = (opcode == OP_NOP);
   assign is_halt   = (opcode == OP_HALT);

   // ---------------------------------------------------------------------
   // Next-state, wait counter and trap logic
   // ---------------------------------------------------------------------
   always_comb begin
      next_state = cur_state;
      next_cnt   = wait_cnt;
      next_trap  = trap_q;
      case (cur_state)
         S_IDLE: if (bus.run) next_state = S_T0;
         S_T0:   next_state = S_T1;
         S_T1: begin
            if (bus.mem_ready) begin
               next_state = S_T2;
               next_cnt   = '0;
            end else if (wait_cnt == WAIT_LAST) begin
               next_state = S_HALT;
               next_trap  = TRAP_TIMEOUT;
               next_cnt   = '0;
            end else begin
               next_cnt = wait_cnt + 4'd1;
            end
         end
         S_T2:   next_state = S_T3;
         S_T3: begin
            if (is_binary || is_muldiv) begin
               next_state = S_T4;
            end else if (is_unary) begin
               next_state = S_T5;
            end else if (is_nop) begin
               next_state = bus.run ? S_T0 : S_IDLE;
            end else if (is_halt) begin
               next_state = S_HALT;
            end else begin
               next_state = S_HALT;
               next_trap  = TRAP_ILLEGAL;
            end
         end
         S_T4:   next_state = S_T5;
         S_T5: begin
            if (is_muldiv) next_state = S_T6;
            else           next_state = bus.run ? S_T0 : S_IDLE;
         end
         S_T6:   next_state = bus.run ? S_T0 : S_IDLE;
         S_HALT: next_state = S_HALT;
         default: next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         cur_state <= RESET_STATE;
         wait_cnt  <= '0;
         trap_q    <= '0;
      end else begin
         cur_state <= next_state;
         wait_cnt  <= next_cnt;
         trap_q    <= next_trap;
      end
   end

   // ---------------------------------------------------------------------
   // Moore output decode
   // ---------------------------------------------------------------------
   always_comb begin
      bus_sel = '0;
      load_en = '0;
      op      = '0;
      inc_pc  = 1'b0;
      mr_read = 1'b0;
      case (cur_state)
         S_T0: begin            // MAR <- PC, Z <- PC + 1
            bus_sel[20] = 1'b1;
            load_en[22] = 1'b1;
            load_en[18] = 1'b1;
            inc_pc      = 1'b1;
            op          = OP_ADD;
         end
         S_T1: begin            // PC <- ZLOW, MDR <- MDataIn (repeat while waiting)
            bus_sel[18] = 1'b1;
            load_en[20] = 1'b1;
            load_en[21] = 1'b1;
            mr_read     = 1'b1;
         end
         S_T2: begin            // IR <- MDR
            bus_sel[21] = 1'b1;
            load_en[23] = 1'b1;
         end
         S_T3: begin
            if (is_binary || is_muldiv) begin
               bus_sel     = 32'd1 << rb;
               load_en[19] = 1'b1;
            end else if (is_unary) begin
               bus_sel     = 32'd1 << rb;
               load_en[18] = 1'b1;
               op          = opcode;
            end
         end
         S_T4: begin            // Z <- Y op Rc
            bus_sel     = 32'd1 << rc;
            load_en[18] = 1'b1;
            op          = opcode;
         end
         S_T5: begin
            bus_sel[18] = 1'b1;
            if (is_muldiv) load_en[17] = 1'b1;
            else           load_en     = 32'd1 << ra;
         end
         S_T6: begin            // HI <- ZHIGH
            bus_sel[19] = 1'b1;
            load_en[16] = 1'b1;
         end
         default: ;
      endcase
   end

   // Gating by clr keeps the Datapath quiet while reset is held even when
   // the reset state is T0.
   assign bus.busSelect = clr ? bus_sel : '0;
   assign bus.enable    = clr ? load_en : '0;
   assign bus.alu_op    = clr ? op      : '0;
   assign bus.IncPC     = clr & inc_pc;
   assign bus.MR_Read   = clr & mr_read;
   assign bus.state     = cur_state;
   assign bus.halted    = (cur_state == S_HALT);
   assign bus.trap      = trap_q;

endmodule
`default_nettype wire

// File: tb/tb_sequencer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sequencer_ctrl
//  Description : Self-checking bench for sequencer_ctrl. Expected per-cycle
//                outputs are queued when an instruction is launched and are
//                popped and compared on each falling clock edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sequencer_ctrl;

   typedef struct {
      string       tag;
      logic [3:0]  st;
      logic [31:0] bs;
      logic [31:0] en;
      logic [4:0]  op;
      logic        inc;
      logic        mr;
      logic        hl;
      logic [1:0]  tr;
   } exp_t;

   logic clk = 1'b0;
   logic clr = 1'b0;
   int   errors = 0;
   int   checks = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   sequencer_ctrl_if bus ();

   sequencer_ctrl #(
      .MAX_WAIT         (15),
      .RESET_STATE_IDLE (1'b1)
   ) dut (
      .clk (clk),
      .clr (clr),
      .bus (bus)
   );

   localparam logic [31:0] IR_SHRA = 32'h40090000;
   localparam logic [31:0] IR_MUL  = 32'h78090000;
   localparam logic [31:0] IR_NEG  = 32'h88090000;
   localparam logic [31:0] IR_ILL  = 32'hF8000000;
   localparam logic [31:0] IR_ADD  = {5'b00011, 4'd3, 4'd4, 4'd5, 15'd0};
   localparam logic [31:0] IR_NOP  = {5'b11010, 27'd0};
   localparam logic [31:0] IR_HALT = {5'b11011, 27'd0};

   function automatic logic [31:0] oh(input int b);
      return 32'd1 << b;
   endfunction

   task automatic push(input string tag, input logic [3:0] st, input logic [31:0] bs,
                       input logic [31:0] en, input logic [4:0] op, input logic inc,
                       input logic mr, input logic hl, input logic [1:0] tr);
      exp_t e;
      e.tag = tag; e.st = st; e.bs = bs; e.en = en; e.op = op;
      e.inc = inc; e.mr = mr; e.hl = hl; e.tr = tr;
      sb.push_back(e);
   endtask

   task automatic push_fetch(input string tag, input int waits);
      push({tag, ".T0"}, 4'd1, oh(20), oh(22) | oh(18), 5'b00011, 1'b1, 1'b0, 1'b0, 2'b00);
      for (int i = 0; i <= waits; i++)
         push({tag, ".T1"}, 4'd2, oh(18), oh(20) | oh(21), 5'd0, 1'b0, 1'b1, 1'b0, 2'b00);
      push({tag, ".T2"}, 4'd3, oh(21), oh(23), 5'd0, 1'b0, 1'b0, 1'b0, 2'b00);
   endtask

   task automatic push_idle(input string tag);
      push({tag, ".IDLE"}, 4'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00);
   endtask

   // Scoreboard consumer: one queued record per clock, compared mid-cycle.
   task automatic monitor();
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            if ({bus.state, bus.busSelect, bus.enable, bus.alu_op, bus.IncPC,
                 bus.MR_Read, bus.halted, bus.trap} !==
                {e.st, e.bs, e.en, e.op, e.inc, e.mr, e.hl, e.tr}) begin
               errors++;
               $display("FAIL %s: got state=%0d bus=%h en=%h op=%b inc=%b mr=%b halted=%b trap=%b, expected state=%0d bus=%h en=%h op=%b inc=%b mr=%b halted=%b trap=%b",
                        e.tag, bus.state, bus.busSelect, bus.enable, bus.alu_op, bus.IncPC,
                        bus.MR_Read, bus.halted, bus.trap,
                        e.st, e.bs, e.en, e.op, e.inc, e.mr, e.hl, e.tr);
            end
         end
      end
   endtask

   task automatic drain();
      for (int g = 0; g < 200 && sb.size() != 0; g++) @(posedge clk);
   endtask

   task automatic launch(input logic [31:0] ir_val, input logic ready);
      @(negedge clk); #1;
      bus.ir        = ir_val;
      bus.mem_ready = ready;
      bus.run       = 1'b1;
   endtask

   task automatic pulse_reset();
      bus.run = 1'b0;
      @(negedge clk); clr = 1'b0;
      @(negedge clk); clr = 1'b1;
   endtask

   task automatic test_reset();
      clr = 1'b0; bus.run = 1'b0; bus.mem_ready = 1'b0; bus.ir = '0;
      repeat (3) @(negedge clk);
      checks++;
      if (bus.state !== 4'd0) begin errors++; $display("FAIL reset_state: got %0d, expected 0", bus.state); end
      checks++;
      if ({bus.busSelect, bus.enable, bus.alu_op, bus.IncPC, bus.MR_Read} !== 71'd0) begin
         errors++; $display("FAIL reset_outputs: got bus=%h en=%h, expected 0", bus.busSelect, bus.enable);
      end
      checks++;
      if ({bus.halted, bus.trap} !== 3'b000) begin
         errors++; $display("FAIL reset_status: got halted=%b trap=%b, expected 0/00", bus.halted, bus.trap);
      end
      clr = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (bus.state !== 4'd0 || bus.busSelect !== 32'd0 || bus.enable !== 32'd0) begin
         errors++; $display("FAIL idle_after_reset: got state=%0d bus=%h, expected 0/0", bus.state, bus.busSelect);
      end
   endtask

   task automatic test_back_to_back();
      launch(IR_SHRA, 1'b1);
      for (int k = 0; k < 2; k++) begin
         push_fetch("shra", 0);
         push("shra.T3", 4'd4, oh(1), oh(19), 5'd0, 1'b0, 1'b0, 1'b0, 2'b00);
         push("shra.T4", 4'd5, oh(2), oh(18), 5'b01000, 1'b0, 1'b0, 1'b0, 2'b00);
         push("shra.T5", 4'd6, oh(18), oh(0), 5'd0, 1'b0, 1'b0, 1'b0, 2'b00);
      end
      push_idle("shra");
      repeat (7) @(negedge clk); #1;
      bus.run = 1'b0;
      drain();
      checks++;
      if (sb.size() !== 0) begin errors++; $display("FAIL shra_drain: got %0d pending, expected 0", sb.size()); sb.delete(); end
   endtask

   task automatic test_mul();
      launch(IR_MUL, 1'b1);
      push_fetch("mul", 0);
      push("mul.T3", 4'd4, oh(1), oh(19), 5'd0, 1'b0, 1'b0, 1'b0, 2'b00);
      push("mul.T4", 4'd5, oh(2), oh(18), 5'b01111, 1'b0, 1'b0, 1'b0, 2'b00);
      push("mul.T5", 4'd6, oh(18), oh(17), 5'd0, 1'b0, 1'b0, 1'b0, 2'b00);
      push("mul.T6", 4'd7, oh(19), oh(16), 5'd0, 1'b0, 1'b0, 1'b0, 2'b00);
      push_idle("mul");
      @(negedge clk); #1;
      bus.run = 1'b0;
      drain();
      checks++;
      if (sb.size() !== 0) begin errors++; $display("FAIL mul_drain: got %0d pending, expected 0", sb.size()); sb.delete(); end
   endtask

   task automatic test_fetch_wait();
      launch(IR_ADD, 1'b0);
      push_fetch("wait", 3);
      push("wait.T3", 4'd4, oh(4), oh(19), 5'd0, 1'b0, 1'b0, 1'b0, 2'b00);
      push("wait.T4", 4'd5, oh(5), oh(18), 5'b00011, 1'b0, 1'b0, 1'b0, 2'b00);
      push("wait.T5", 4'd6, oh(18), oh(3), 5'd0, 1'b0, 1'b0, 1'b0, 2'b00);
      push_idle("wait");
      @(negedge clk); #1;
      bus.run = 1'b0;
      repeat (4) @(negedge clk); #1;
      bus.mem_ready = 1'b1;
      drain();
      checks++;
      if (sb.size() !== 0) begin errors++; $display("FAIL wait_drain: got %0d pending, expected 0", sb.size()); sb.delete(); end
   endtask

   task automatic test_fetch_timeout();
      launch(IR_ADD, 1'b0);
      push("tmo.T0", 4'd1, oh(20), oh(22) | oh(18), 5'b00011, 1'b1, 1'b0, 1'b0, 2'b00);
      for (int i = 0; i < 15; i++)
         push("tmo.T1", 4'd2, oh(18), oh(20) | oh(21), 5'd0, 1'b0, 1'b1, 1'b0, 2'b00);
      for (int i = 0; i < 3; i++)
         push("tmo.HALT", 4'd8, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1, 2'b10);
      @(negedge clk); #1;
      bus.run = 1'b0;
      drain();
      checks++;
      if (sb.size() !== 0) begin errors++; $display("FAIL tmo_drain: got %0d pending, expected 0", sb.size()); sb.delete(); end
      bus.run = 1'b1; bus.mem_ready = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (bus.state !== 4'd8 || bus.trap !== 2'b10 || bus.halted !== 1'b1) begin
         errors++; $display("FAIL halt_sticky: got state=%0d trap=%b halted=%b, expected 8/10/1", bus.state, bus.trap, bus.halted);
      end
      pulse_reset();
      checks++;
      if (bus.trap !== 2'b00 || bus.halted !== 1'b0 || bus.state !== 4'd0) begin
         errors++; $display("FAIL trap_clear: got trap=%b halted=%b state=%0d, expected 00/0/0", bus.trap, bus.halted, bus.state);
      end
   endtask

   task automatic test_opcode_classes();
      launch(IR_NOP, 1'b1);
      push_fetch("nop", 0);
      push("nop.T3", 4'd4, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00);
      push_idle("nop");
      @(negedge clk); #1; bus.run = 1'b0;
      drain();

      launch(IR_NEG, 1'b1);
      push_fetch("neg", 0);
      push("neg.T3", 4'd4, oh(1), oh(18), 5'b10001, 1'b0, 1'b0, 1'b0, 2'b00);
      push("neg.T5", 4'd6, oh(18), oh(0), 5'd0, 1'b0, 1'b0, 1'b0, 2'b00);
      push_idle("neg");
      @(negedge clk); #1; bus.run = 1'b0;
      drain();

      launch(IR_HALT, 1'b1);
      push_fetch("halt", 0);
      push("halt.T3", 4'd4, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00);
      push("halt.HALT", 4'd8, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1, 2'b00);
      push("halt.HALT", 4'd8, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1, 2'b00);
      drain();
      pulse_reset();

      launch(IR_ILL, 1'b1);
      push_fetch("ill", 0);
      push("ill.T3", 4'd4, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00);
      push("ill.HALT", 4'd8, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1, 2'b01);
      push("ill.HALT", 4'd8, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1, 2'b01);
      drain();
      checks++;
      if (sb.size() !== 0) begin errors++; $display("FAIL classes_drain: got %0d pending, expected 0", sb.size()); sb.delete(); end
      pulse_reset();
   endtask

   task automatic test_run_drop();
      launch(IR_ADD, 1'b1);
      for (int k = 0; k < 2; k++) begin
         push_fetch("drop", 0);
         push("drop.T3", 4'd4, oh(4), oh(19), 5'd0, 1'b0, 1'b0, 1'b0, 2'b00);
         push("drop.T4", 4'd5, oh(5), oh(18), 5'b00011, 1'b0, 1'b0, 1'b0, 2'b00);
         push("drop.T5", 4'd6, oh(18), oh(3), 5'd0, 1'b0, 1'b0, 1'b0, 2'b00);
         push_idle("drop");
         if (k == 0) push_idle("drop");
      end
      repeat (5) @(negedge clk); #1; bus.run = 1'b0;   // during T4
      repeat (3) @(negedge clk); #1; bus.run = 1'b1;   // second IDLE cycle
      @(negedge clk); #1; bus.run = 1'b0;
      drain();
      checks++;
      if (sb.size() !== 0) begin errors++; $display("FAIL drop_drain: got %0d pending, expected 0", sb.size()); sb.delete(); end
   endtask

   task automatic test_async_reset();
      launch(IR_ADD, 1'b1);
      push_fetch("arst", 0);
      push("arst.T3", 4'd4, oh(4), oh(19), 5'd0, 1'b0, 1'b0, 1'b0, 2'b00);
      push("arst.T4", 4'd5, oh(5), oh(18), 5'b00011, 1'b0, 1'b0, 1'b0, 2'b00);
      repeat (5) @(negedge clk); #1;
      clr = 1'b0;
      bus.run = 1'b0;
      #1;
      checks++;
      if (bus.state !== 4'd0 || bus.busSelect !== 32'd0 || bus.enable !== 32'd0 || bus.alu_op !== 5'd0) begin
         errors++; $display("FAIL async_reset: got state=%0d bus=%h en=%h op=%b, expected all 0",
                            bus.state, bus.busSelect, bus.enable, bus.alu_op);
      end
      @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.state !== 4'd0 || sb.size() !== 0) begin
         errors++; $display("FAIL async_release: got state=%0d pending=%0d, expected 0/0", bus.state, sb.size());
      end
   endtask

   initial begin
      fork
         monitor();
      join_none
      test_reset();
      test_back_to_back();
      test_mul();
      test_fetch_wait();
      test_fetch_timeout();
      test_opcode_classes();
      test_run_drop();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, expected finish before 200000");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire

// File: doc/sequencer_ctrl.md
Name: sequencer_ctrl

Overview:
- Hardwired control unit that sequences the Phase-1 Datapath through fetch, decode and execute for register-register ALU instructions.
- Drives the Datapath source one-hot, the destination-enable one-hot, the ALU opcode, IncPC and MR_Read each cycle.
- Reads the Datapath IR contents back.
- Handles a memory-ready wait on instruction fetch, run/halt, and illegal-opcode trapping.

Parameters:
MAX_WAIT, 15, maximum cycles in T1 waiting for mem_ready before a fetch-timeout trap (4-bit counter)
RESET_STATE_IDLE, 1, 1: come out of reset in IDLE and wait for run; 0: go straight to T0

Ports:
clk  input  1  system clock, rising edge
clr  input  1  asynchronous active-low reset
run  input  1  level; begin/continue execution from IDLE
mem_ready  input  1  memory has valid data on MDataIn this cycle
ir  input  32  current Datapath IR contents (valid from T3)
busSelect  output  32  one-hot bus source. Bit indices: 0-15 R0-R15, 16 HI, 17 LO, 18 ZLOW, 19 ZHIGH, 20 PC, 21 MDR
enable  output  32  one-hot-or-multi register load enables. Bit indices: 0-15 R0-R15, 16 HI, 17 LO, 18 Z, 19 Y, 20 PC, 21 MDR, 22 MAR, 23 IR
alu_op  output  5  ALU operation code (opcode field, or ADD=00011 for PC increment)
IncPC  output  1  ALU adds 1 to the bus operand
MR_Read  output  1  MDR mux selects MDataIn
state  output  4  current state encoding, for debug/bench
halted  output  1  controller in HALT
trap  output  2  00 none, 01 illegal opcode, 10 fetch timeout; sticky until reset

Behaviour:
- Instruction fields: opcode=ir[31:27], Ra=ir[26:23], Rb=ir[22:19], Rc=ir[18:15].
- Opcodes:
  - Binary: 00011 add, 00100 sub, 00101 and, 00110 or, 00111 shr, 01000 shra, 01001 shl, 01010 ror, 01011 rol.
  - Mul/div: 01111 mul, 10000 div.
  - Unary: 10001 neg, 10010 not.
  - Other: 11010 nop, 11011 halt.
  - Anything else is illegal.
- States: IDLE=0, T0=1, T1=2, T2=3, T3=4, T4=5, T5=6, T6=7, HALT=8. Moore outputs, decoded combinationally from state and ir. All outputs are 0 in IDLE/HALT and during reset.
- Reset (clr low, async): state=IDLE (T0 if RESET_STATE_IDLE=0), wait counter=0, trap=00, halted=0. Reset mid-instruction abandons the instruction; outputs drop immediately.
- IDLE: run=1 -> T0, else stay.
- T0: busSelect[20], enable[22]|enable[18], IncPC=1, alu_op=00011. -> T1.
- T1: busSelect[18], enable[20]|enable[21], MR_Read=1.
  - mem_ready=1 -> T2.
  - Otherwise stay and increment the wait counter. PC and MDR enables stay asserted; the PC reload is idempotent.
  - Counter reaching MAX_WAIT with mem_ready still 0 -> HALT, trap=10.
  - Counter clears on leaving T1.
- T2: busSelect[21], enable[23]. -> T3.
- T3 (decode on ir):
  - Binary and mul/div: busSelect[Rb], enable[19]. -> T4.
  - Unary: busSelect[Rb], enable[18], alu_op=opcode. -> T5.
  - nop: no outputs. -> T0 if run, else IDLE.
  - halt: -> HALT.
  - Illegal: -> HALT, trap=01.
- T4: busSelect[Rc], enable[18], alu_op=opcode. -> T5.
- T5:
  - Mul/div: busSelect[18], enable[17] (LO). -> T6.
  - Otherwise: busSelect[18], enable[Ra]. -> T0 if run, else IDLE.
- T6 (mul/div only): busSelect[19], enable[16] (HI). -> T0 if run, else IDLE.
- HALT: halted=1. Leaves only via reset.
- run is sampled only at instruction boundaries (IDLE, end of T5/T6/nop). Deasserting run mid-instruction completes the current instruction.
- Invariants:
  - busSelect is zero or exactly one-hot in every cycle.
  - IncPC is high only in T0.
  - MR_Read is high only in T1.
- Ra=Rb=Rc is legal. Y latches first, so the result is correct.
- Cycle count with mem_ready tied high:
  - Binary: 6 cycles (T0-T5).
  - Mul/div: 7 cycles.
  - Unary: 5 cycles.
  - nop: 4 cycles.

Test Plan:
- Reset/idle: hold clr=0, then release with run=0 -> state=0, all outputs 0, trap=00. Pulse clr=0 during T4 -> outputs zero asynchronously, before the next edge.
- shra: run=1, mem_ready=1, ir=32'h40090000 -> T3 busSelect=bit1, enable=bit19; T4 busSelect=bit2, enable=bit18, alu_op=01000; T5 busSelect=bit18, enable=bit0; back to T0 after 6 cycles.
- Mul: ir=32'h78090000 -> T5 enable=bit17 (LO), T6 busSelect=bit19, enable=bit16; 7-cycle instruction.
- Fetch wait: mem_ready low for 3 cycles in T1 -> T1 held 4 cycles with MR_Read=1, then T2. mem_ready low for 15 cycles -> HALT, trap=10, halted=1.
- Unary/illegal: ir=32'h88090000 (neg R0,R1) -> T3 enable=bit18, alu_op=10001, skips T4. ir=32'hF8000000 -> HALT, trap=01.
- run drop: deassert run in T4 of an add -> completes T5, then enters IDLE. Reassert run -> T0 next cycle.
